// File: rtl/hack_soc_pkg.sv
// Shared definitions for the hack_soc memory subsystem: arbiter state
// encoding and requester identities.
package hack_soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_e;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_DISP = 1'b1;

endpackage

// File: rtl/qspi_ram_arbiter.sv
// Two-requester arbiter in front of the QSPI SRAM controller. The CPU data
// port (read/write) and the display fetcher (read-only) take turns owning the
// controller; a watchdog forces completion if the controller never answers.
module qspi_ram_arbiter
    import hack_soc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_ack,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    output logic                  mem_start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_done,
    input  logic                  mem_busy,
    output logic                  owner,
    output logic                  timeout_err
);

    // Counter runs 0..TIMEOUT_CYCLES-1 while waiting; the last value is the
    // final WAIT cycle before the forced completion.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  start_q, start_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  disp_ack_q, disp_ack_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] disp_rdata_q, disp_rdata_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  grant_owner;

    // Round-robin pick: under contention the requester that did not own the
    // controller last time wins; otherwise whoever is asking.
    always_comb begin
        grant_owner = OWNER_CPU;
        if (cpu_req && disp_req) begin
            grant_owner = ~last_owner_q;
        end else if (disp_req) begin
            grant_owner = OWNER_DISP;
        end
    end

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        start_d       = 1'b0;
        cpu_ack_d     = 1'b0;
        disp_ack_d    = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        disp_rdata_d  = disp_rdata_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!mem_busy && (cpu_req || disp_req)) begin
                    owner_d = grant_owner;
                    if (grant_owner == OWNER_DISP) begin
                        // Display is read-only; its command never writes.
                        we_d    = 1'b0;
                        addr_d  = disp_addr;
                        wdata_d = '0;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done || (cnt_q == CNT_LAST)) begin
                    // A real completion wins over a simultaneous timeout.
                    if (!mem_done) begin
                        timeout_err_d = 1'b1;
                    end
                    if (!we_q) begin
                        if (owner_q == OWNER_DISP) begin
                            disp_rdata_d = mem_done ? mem_rdata : '0;
                        end else begin
                            cpu_rdata_d = mem_done ? mem_rdata : '0;
                        end
                    end
                    cpu_ack_d  = (owner_q == OWNER_CPU);
                    disp_ack_d = (owner_q == OWNER_DISP);
                    state_d    = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_DISP;
            last_owner_q  <= OWNER_DISP;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            start_q       <= 1'b0;
            cpu_ack_q     <= 1'b0;
            disp_ack_q    <= 1'b0;
            cpu_rdata_q   <= '0;
            disp_rdata_q  <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            start_q       <= start_d;
            cpu_ack_q     <= cpu_ack_d;
            disp_ack_q    <= disp_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            disp_rdata_q  <= disp_rdata_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign mem_start   = start_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign disp_ack    = disp_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign disp_rdata  = disp_rdata_q;
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_qspi_ram_arbiter.sv
`timescale 1ns/1ps
module tb_qspi_ram_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        disp_req = 1'b0;
    logic [15:0] disp_addr = '0;
    logic        disp_ack;
    logic [15:0] disp_rdata;
    logic        mem_start, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done, mem_busy;
    logic        owner, timeout_err;

    qspi_ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
        .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_busy(mem_busy),
        .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // ---------------- controller model (environment) ----------------
    logic [15:0] ram [logic [15:0]];
    int  ctl_lat = 3;
    bit  ctl_hang = 0, ctl_force_busy = 0, ctl_inject = 0, ctl_clear = 0;
    int  ctl_cnt = -1;
    logic        ctl_we;
    logic [15:0] ctl_addr, ctl_wdata;
    int  start_cyc = -1, done_cyc = -1, n_starts = 0;

    initial begin
        mem_done = 1'b0; mem_busy = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_done = 1'b0;
            if (ctl_clear) begin ctl_cnt = -1; ctl_clear = 0; end
            if (ctl_inject) begin
                mem_done = 1'b1; mem_rdata = 16'hDEAD; ctl_inject = 0;
            end else if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    mem_done = 1'b1; done_cyc = cyc;
                    if (ctl_we) ram[ctl_addr] = ctl_wdata;
                    else mem_rdata = ram.exists(ctl_addr) ? ram[ctl_addr] : (ctl_addr ^ 16'h5A5A);
                    ctl_cnt = -1;
                end
            end
            if (mem_start) begin
                ctl_we = mem_we; ctl_addr = mem_addr; ctl_wdata = mem_wdata;
                start_cyc = cyc; n_starts++;
                ctl_cnt = ctl_hang ? -2 : ctl_lat;
            end
            mem_busy = ctl_force_busy || (ctl_cnt != -1);
        end
    end

    int n_cpu_ack = 0, n_disp_ack = 0;
    initial forever begin
        @(posedge clk); #1;
        if (cpu_ack) n_cpu_ack++;
        if (disp_ack) n_disp_ack++;
    end

    // ---------------- reference model ----------------
    logic [15:0] shadow [logic [15:0]];
    logic [15:0] exp_cpu = '0, exp_disp = '0;
    logic        model_last = 1'b1;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (shadow.exists(a)) return shadow[a];
        return a ^ 16'h5A5A;
    endfunction

    function automatic void model_apply(input logic who, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (who == 1'b0 && we) shadow[a] = d;
        else if (who == 1'b0) exp_cpu = model_read(a);
        else exp_disp = model_read(a);
        model_last = who;
    endfunction

    function automatic void model_reset();
        exp_cpu = '0; exp_disp = '0; model_last = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk); #2;
    endtask

    // One complete transaction from an IDLE cycle; leaves the DUT in IDLE.
    task automatic run_xact(input logic who, input logic we, input logic [15:0] a, input logic [15:0] d,
                            output bit got, output int req_at, output int ack_at);
        req_at = cyc; got = 0; ack_at = -1;
        if (who == 1'b0) begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
        else begin disp_addr = a; disp_req = 1'b1; end
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if ((who == 1'b0 && cpu_ack) || (who == 1'b1 && disp_ack)) begin got = 1; ack_at = cyc; end
        end
        cpu_req = 1'b0; disp_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick(); tick();
        n_checks++; if (mem_start !== 1'b0) begin n_fail++; $display("FAIL reset_mem_start: got %b want 0", mem_start); end
        n_checks++; if (cpu_ack !== 1'b0 || disp_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: got %b%b want 00", cpu_ack, disp_ack); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
        n_checks++; if (cpu_rdata !== 16'h0 || disp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, disp_rdata); end
        n_checks++; if ({mem_we, mem_addr, mem_wdata} !== 33'h0) begin n_fail++; $display("FAIL reset_cmd: got %b %h %h want 0", mem_we, mem_addr, mem_wdata); end
        reset_n = 1'b1; tick();
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_cpu_write();
        bit got = 0;
        ctl_lat = 5;
        cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
        tick();
        n_checks++; if (mem_start !== 1'b1) begin n_fail++; $display("FAIL wr_start: got %b want 1", mem_start); end
        n_checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0010, 16'hBEEF}) begin n_fail++; $display("FAIL wr_cmd: got %b %h %h want 1 0010 beef", mem_we, mem_addr, mem_wdata); end
        for (int i = 0; i < 40 && !got; i++) begin tick(); if (cpu_ack) got = 1; end
        cpu_req = 1'b0;
        n_checks++; if (!got || cyc !== done_cyc + 1) begin n_fail++; $display("FAIL wr_ack_timing: got ack=%0d at %0d want at %0d", got, cyc, done_cyc + 1); end
        n_checks++; if (done_cyc - start_cyc !== 5) begin n_fail++; $display("FAIL wr_ctl_latency: got %0d want 5", done_cyc - start_cyc); end
        tick();
        n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b want 0", cpu_ack); end
        model_apply(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        n_checks++; if (cpu_rdata !== exp_cpu) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want %h", cpu_rdata, exp_cpu); end
        $display("test_cpu_write addr=0010 data=beef ack_cycle=%0d", cyc - 1);
    endtask

    task automatic test_disp_read();
        bit got; int req_at, ack_at;
        logic [15:0] a;
        a = 16'h0100 + 16'($urandom_range(0, 255));
        ctl_lat = 2;
        run_xact(1'b0, 1'b0, a, 16'h0, got, req_at, ack_at);
        model_apply(1'b0, 1'b0, a, 16'h0);
        n_checks++; if (!got || cpu_rdata !== exp_cpu) begin n_fail++; $display("FAIL cpu_read: got ack=%0d %h want %h", got, cpu_rdata, exp_cpu); end
        ram[16'h4000] = 16'h1234; shadow[16'h4000] = 16'h1234;
        cpu_we = 1'b1;
        run_xact(1'b1, 1'b0, 16'h4000, 16'h0, got, req_at, ack_at);
        model_apply(1'b1, 1'b0, 16'h4000, 16'h0);
        n_checks++; if (!got || disp_rdata !== 16'h1234) begin n_fail++; $display("FAIL disp_read: got ack=%0d %h want 1234", got, disp_rdata); end
        n_checks++; if (cpu_rdata !== exp_cpu) begin n_fail++; $display("FAIL disp_cpu_rdata_kept: got %h want %h", cpu_rdata, exp_cpu); end
        n_checks++; if (ctl_we !== 1'b0 || owner !== 1'b1) begin n_fail++; $display("FAIL disp_cmd: got we=%b owner=%b want 0 1", ctl_we, owner); end
        cpu_we = 1'b0;
        $display("test_disp_read addr=4000 rdata=%h", disp_rdata);
    endtask

    task automatic test_random();
        bit got; int req_at, ack_at;
        logic who, we; logic [15:0] a, d;
        for (int k = 0; k < 12; k++) begin
            who = 1'($urandom_range(0, 1));
            we = (who == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = 16'h0100 + 16'($urandom_range(0, 7));
            d = 16'($urandom);
            ctl_lat = $urandom_range(1, 6);
            run_xact(who, we, a, d, got, req_at, ack_at);
            model_apply(who, we, a, d);
            n_checks++; if (!got || start_cyc !== req_at + 1 || ack_at !== done_cyc + 1) begin n_fail++; $display("FAIL rnd_timing[%0d]: ack=%0d start=%0d req=%0d ack_at=%0d done=%0d", k, got, start_cyc, req_at, ack_at, done_cyc); end
            n_checks++; if (cpu_rdata !== exp_cpu || disp_rdata !== exp_disp) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h/%h want %h/%h", k, cpu_rdata, disp_rdata, exp_cpu, exp_disp); end
            n_checks++; if (owner !== who) begin n_fail++; $display("FAIL rnd_owner[%0d]: got %b want %b", k, owner, who); end
            $display("xact %0d who=%0d we=%0d addr=%h data=%h lat=%0d cpu_rdata=%h disp_rdata=%h", k, who, we, a, d, ctl_lat, cpu_rdata, disp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        bit got; int s1, s2, req_at, ack_at;
        logic [15:0] a1, d1, d2;
        a1 = 16'h2000 + 16'($urandom_range(0, 255)); d1 = 16'($urandom); d2 = 16'($urandom);
        ctl_lat = 1;
        cpu_we = 1'b1; cpu_addr = a1; cpu_wdata = d1; cpu_req = 1'b1;
        got = 0; for (int i = 0; i < 20 && !got; i++) begin tick(); if (cpu_ack) got = 1; end
        s1 = start_cyc;
        cpu_addr = a1 + 16'd1; cpu_wdata = d2;
        n_checks++; if (!got) begin n_fail++; $display("FAIL b2b_first_ack: got none want ack"); end
        got = 0; for (int i = 0; i < 20 && !got; i++) begin tick(); if (cpu_ack) got = 1; end
        s2 = start_cyc;
        cpu_req = 1'b0; tick();
        n_checks++; if (!got || s2 - s1 !== 4) begin n_fail++; $display("FAIL b2b_spacing: got ack=%0d spacing %0d want 4", got, s2 - s1); end
        model_apply(1'b0, 1'b1, a1, d1); model_apply(1'b0, 1'b1, a1 + 16'd1, d2);
        run_xact(1'b0, 1'b0, a1, 16'h0, got, req_at, ack_at); model_apply(1'b0, 1'b0, a1, 16'h0);
        n_checks++; if (!got || cpu_rdata !== exp_cpu) begin n_fail++; $display("FAIL b2b_read1: got %h want %h", cpu_rdata, exp_cpu); end
        run_xact(1'b0, 1'b0, a1 + 16'd1, 16'h0, got, req_at, ack_at); model_apply(1'b0, 1'b0, a1 + 16'd1, 16'h0);
        n_checks++; if (!got || cpu_rdata !== exp_cpu) begin n_fail++; $display("FAIL b2b_read2: got %h want %h", cpu_rdata, exp_cpu); end
        $display("test_back_to_back starts %0d,%0d data %h,%h", s1, s2, d1, d2);
    endtask

    task automatic test_timeout();
        bit got = 0; int issue_at, req_at, ack_at;
        ctl_hang = 1;
        cpu_we = 1'b0; cpu_addr = 16'h0105; cpu_req = 1'b1;
        tick();
        issue_at = cyc;
        n_checks++; if (mem_start !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b want 1", mem_start); end
        for (int i = 0; i < 40 && !got; i++) begin tick(); if (cpu_ack) got = 1; end
        cpu_req = 1'b0;
        exp_cpu = 16'h0; model_last = 1'b0;
        n_checks++; if (!got || cyc - issue_at !== TO + 1) begin n_fail++; $display("FAIL to_latency: got ack=%0d after %0d want %0d", got, cyc - issue_at, TO + 1); end
        n_checks++; if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0000", cpu_rdata); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", timeout_err); end
        ctl_hang = 0; ctl_clear = 1; tick(); tick();
        run_xact(1'b1, 1'b0, 16'h0103, 16'h0, got, req_at, ack_at); model_apply(1'b1, 1'b0, 16'h0103, 16'h0);
        n_checks++; if (!got || disp_rdata !== exp_disp) begin n_fail++; $display("FAIL to_recover: got %h want %h", disp_rdata, exp_disp); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        $display("test_timeout ack after %0d cycles, timeout_err=%b", TO + 1, timeout_err);
    endtask

    task automatic test_reset_mid();
        bit got = 0; int acks0, starts0, release_at;
        ctl_lat = 10;
        cpu_we = 1'b0; cpu_addr = 16'h0102; cpu_req = 1'b1;
        tick(); tick(); tick();
        reset_n = 1'b0; cpu_req = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        n_checks++; if (cpu_ack !== 1'b0 || disp_ack !== 1'b0 || mem_start !== 1'b0) begin n_fail++; $display("FAIL rm_pulses: got %b%b%b want 000", cpu_ack, disp_ack, mem_start); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rm_terr: got %b want 0", timeout_err); end
        n_checks++; if (cpu_rdata !== 16'h0 || disp_rdata !== 16'h0 || {mem_we, mem_addr, mem_wdata} !== 33'h0) begin n_fail++; $display("FAIL rm_regs: got %h %h %b %h %h want zeros", cpu_rdata, disp_rdata, mem_we, mem_addr, mem_wdata); end
        ctl_force_busy = 1;
        acks0 = n_cpu_ack + n_disp_ack; starts0 = n_starts;
        cpu_addr = 16'h0106; cpu_req = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_checks++; if (n_starts !== starts0 || n_cpu_ack + n_disp_ack !== acks0) begin n_fail++; $display("FAIL rm_held_off: got starts+%0d acks+%0d want 0 0", n_starts - starts0, n_cpu_ack + n_disp_ack - acks0); end
        ctl_force_busy = 0; release_at = cyc;
        for (int i = 0; i < 30 && !got; i++) begin tick(); if (cpu_ack) got = 1; end
        cpu_req = 1'b0; tick();
        model_apply(1'b0, 1'b0, 16'h0106, 16'h0);
        n_checks++; if (!got || start_cyc <= release_at || cpu_rdata !== exp_cpu) begin n_fail++; $display("FAIL rm_resume: got ack=%0d start=%0d rdata=%h want start>%0d rdata=%h", got, start_cyc, cpu_rdata, release_at, exp_cpu); end
        $display("test_reset_mid resumed start=%0d rdata=%h", start_cyc, cpu_rdata);
    endtask

    task automatic test_spurious_done();
        bit got; int acks0, starts0, req_at, ack_at;
        acks0 = n_cpu_ack + n_disp_ack; starts0 = n_starts;
        ctl_inject = 1;
        tick(); tick(); tick(); tick();
        n_checks++; if (n_cpu_ack + n_disp_ack !== acks0 || n_starts !== starts0) begin n_fail++; $display("FAIL sp_no_ack: got acks+%0d starts+%0d want 0 0", n_cpu_ack + n_disp_ack - acks0, n_starts - starts0); end
        n_checks++; if (cpu_rdata !== exp_cpu || disp_rdata !== exp_disp) begin n_fail++; $display("FAIL sp_rdata: got %h/%h want %h/%h", cpu_rdata, disp_rdata, exp_cpu, exp_disp); end
        ctl_lat = 2;
        run_xact(1'b1, 1'b0, 16'h0104, 16'h0, got, req_at, ack_at); model_apply(1'b1, 1'b0, 16'h0104, 16'h0);
        n_checks++; if (!got || start_cyc !== req_at + 1 || disp_rdata !== exp_disp) begin n_fail++; $display("FAIL sp_after: got ack=%0d start=%0d rdata=%h want start=%0d rdata=%h", got, start_cyc, disp_rdata, req_at + 1, exp_disp); end
        $display("test_spurious_done disp_rdata=%h", disp_rdata);
    endtask

    task automatic test_contention();
        bit got; logic exp_o;
        logic [15:0] ca, da;
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        model_reset();
        ca = 16'h3000 + 16'($urandom_range(0, 255)); da = 16'h4100 + 16'($urandom_range(0, 255));
        ctl_lat = 2;
        cpu_we = 1'b0; cpu_addr = ca; disp_addr = da; cpu_req = 1'b1; disp_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_o = ~model_last;
            got = 0; for (int i = 0; i < 30 && !got; i++) begin tick(); if (mem_start) got = 1; end
            n_checks++; if (!got || owner !== exp_o || mem_addr !== (exp_o ? da : ca)) begin n_fail++; $display("FAIL ct_grant[%0d]: got start=%0d owner=%b addr=%h want owner=%b addr=%h", k, got, owner, mem_addr, exp_o, exp_o ? da : ca); end
            got = 0; for (int i = 0; i < 30 && !got; i++) begin tick(); if (cpu_ack || disp_ack) got = 1; end
            if (k == 5) begin cpu_req = 1'b0; disp_req = 1'b0; end
            model_apply(exp_o, 1'b0, exp_o ? da : ca, 16'h0);
            n_checks++; if (!got || cpu_ack !== ~exp_o || disp_ack !== exp_o) begin n_fail++; $display("FAIL ct_ack[%0d]: got %b%b want cpu=%b disp=%b", k, cpu_ack, disp_ack, ~exp_o, exp_o); end
            n_checks++; if (cpu_rdata !== exp_cpu || disp_rdata !== exp_disp) begin n_fail++; $display("FAIL ct_rdata[%0d]: got %h/%h want %h/%h", k, cpu_rdata, disp_rdata, exp_cpu, exp_disp); end
            $display("contention grant %0d owner=%s", k, exp_o ? "DISP" : "CPU");
        end
        tick(); tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_write();
        test_disp_read();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_spurious_done();
        test_contention();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_ram_arbiter.md
# qspi_ram_arbiter

Shares the single QSPI serial SRAM controller of `hack_soc` between two requesters: the Hack CPU data port (read/write) and the display VRAM fetcher (read-only). The arbiter sits between the requesters and the controller's command/done handshake. It grants the controller to one requester at a time, alternates ownership under contention, and returns read data and a one-cycle acknowledge to the owner. A watchdog bounds every transaction so a hung controller cannot stall the CPU or the display.

## Interface
- `ADDR_WIDTH`, 16: word address width.
- `DATA_WIDTH`, 16: word width.
- `TIMEOUT_CYCLES`, 1023: maximum WAIT cycles before forced completion.
- `clk  in  1`: single clock.
- `reset_n  in  1`: reset, synchronous, active-low.
- `cpu_req  in  1`: CPU request, level, held until `cpu_ack`.
- `cpu_we  in  1`: 1 = write.
- `cpu_addr  in  ADDR_WIDTH`: CPU address.
- `cpu_wdata  in  DATA_WIDTH`: CPU write data.
- `cpu_ack  out  1`: one-cycle completion pulse.
- `cpu_rdata  out  DATA_WIDTH`: read data; valid while `cpu_ack` = 1 and held until the next CPU completion.
- `disp_req  in  1`: display read request, level.
- `disp_addr  in  ADDR_WIDTH`: display address.
- `disp_ack  out  1`: one-cycle completion pulse.
- `disp_rdata  out  DATA_WIDTH`: display read data; same validity rule as `cpu_rdata`.
- `mem_start  out  1`: one-cycle command pulse to the controller.
- `mem_we`, `mem_addr`, `mem_wdata`  `out`: registered command; stable from ISSUE through WAIT.
- `mem_rdata  in  DATA_WIDTH`: controller read data; valid with `mem_done`.
- `mem_done  in  1`: controller completion pulse.
- `mem_busy  in  1`: controller busy.
- `owner  out  1`: 0 = CPU, 1 = display. Current or last owner.
- `timeout_err  out  1`: sticky flag; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Waits for `mem_busy` = 0 and at least one request.
  - With one request, grants that requester.
  - With both requests, grants the requester that is not `last_owner` (round-robin).
  - On grant, latches owner, we, addr, wdata, then moves to ISSUE.
  - Display commands always have `mem_we` = 0.
- ISSUE: `mem_start` = 1 for exactly one cycle, then WAIT. The timeout counter clears to 0.
- WAIT:
  - On `mem_done`, latches `mem_rdata` into the owner's rdata register and moves to RESPOND.
  - If the counter reaches `TIMEOUT_CYCLES` first, latches 0 as rdata, sets `timeout_err`, and moves to RESPOND.
  - `mem_done` outside WAIT is ignored.
- RESPOND: pulses the owner's ack for one cycle, sets `last_owner` to the owner, then returns to IDLE.
- For writes, the owner's rdata register is left unchanged.
- A requester must drop its request on the edge where it samples ack = 1. A request still high in the following IDLE cycle is a new transaction; back-to-back transactions are legal.
- Request inputs are sampled only in IDLE. Address and data changes after grant have no effect.
- Reset (`reset_n` = 0 at a clock edge), including mid-transaction:
  - State returns to IDLE.
  - `mem_start`, `cpu_ack`, `disp_ack`, and `timeout_err` = 0.
  - rdata registers and the command registers = 0.
  - `last_owner` = 1, so the CPU wins the first tie.
  - An abandoned controller transaction is not acked. The arbiter waits in IDLE for `mem_busy` = 0 before issuing again.

## Timing
- Request seen in IDLE at cycle N → `mem_start` at N+1.
- `mem_done` at cycle M (in WAIT) → ack and rdata at M+1 → IDLE at M+2.
- Minimum request-to-ack latency = 3 cycles plus controller latency.
- Minimum spacing between two `mem_start` pulses = 4 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Under continuous contention, CPU and display alternate strictly. Worst-case wait for either requester is one foreign transaction.
- Timeout: forced RESPOND no later than `TIMEOUT_CYCLES` + 1 cycles after ISSUE.

## Structure
- Shared package `hack_soc_pkg` holds:
  - the state enumeration (IDLE/ISSUE/WAIT/RESPOND);
  - the owner constants OWNER_CPU = 0 and OWNER_DISP = 1.
- A single module, with no sub-module. The round-robin pick is two-requester logic and is written inline. The timeout counter is a local register.

## Test plan
- CPU-only write, addr 0x0010, data 0xBEEF; controller `mem_done` 5 cycles after start:
  - `mem_start` one cycle after `cpu_req`, with `mem_we` = 1, `mem_addr` = 0x0010, `mem_wdata` = 0xBEEF;
  - `cpu_ack` one cycle after `mem_done`.
- Both requesters held high for 6 transactions, starting from reset → grants are CPU, DISP, CPU, DISP, CPU, DISP, with `owner` toggling each time.
- Display read at 0x4000; controller returns 0x1234 → `disp_ack` pulses with `disp_rdata` = 0x1234; `cpu_rdata` is unchanged.
- Controller never asserts `mem_done`, `TIMEOUT_CYCLES` = 15:
  - ack arrives 16 cycles after ISSUE with rdata = 0;
  - `timeout_err` = 1 and stays 1 until reset.
- `reset_n` pulsed low during WAIT:
  - next cycle, all outputs are at reset values and no ack is produced;
  - a request while `mem_busy` = 1 is held off until busy drops.
- `mem_done` injected while in IDLE → no ack and no state change.
